// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Purpose : Operand forwarding, load-use stall and taken-branch flush control
//           for a 5-stage pipeline. Optional counters: PIPE_HAZARD_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl (
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        duse_rs,
  input  logic        duse_rt,
  input  logic        dbranch_taken,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ebubble,
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        wpcir,
  output logic        dbubble,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic load_use;
  logic [1:0] fwd_a, fwd_b;

  assign ex_match_a  = duse_rs & ewreg & ~ebubble & (ern != 5'd0) & (ern == drs);
  assign ex_match_b  = duse_rt & ewreg & ~ebubble & (ern != 5'd0) & (ern == drt);
  assign mem_match_a = duse_rs & mwreg & (mrn != 5'd0) & (mrn == drs);
  assign mem_match_b = duse_rt & mwreg & (mrn != 5'd0) & (mrn == drt);

  assign load_use = em2reg & (ex_match_a | ex_match_b);

  // A load still in EX cannot be forwarded, so it falls through to the MEM check.
  always_comb begin
    fwd_a = 2'b00;
    if (ex_match_a && !em2reg) fwd_a = 2'b01;
    else if (mem_match_a)      fwd_a = mm2reg ? 2'b11 : 2'b10;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (ex_match_b && !em2reg) fwd_b = 2'b01;
    else if (mem_match_b)      fwd_b = mm2reg ? 2'b11 : 2'b10;
  end

  always_comb begin
    fwda    = fwd_a;
    fwdb    = fwd_b;
    wpcir   = 1'b1;
    dbubble = 1'b0;
    state_d = RUN;
    case (state_q)
      STALL: begin
        state_d = dbranch_taken ? FLUSH : RUN;
      end
      FLUSH: begin
        dbubble = 1'b1;
      end
      default: begin
        // Load-use wins over a taken branch; the branch re-resolves after the stall.
        if (load_use) begin
          wpcir   = 1'b0;
          dbubble = 1'b1;
          state_d = STALL;
        end else if (dbranch_taken) begin
          state_d = FLUSH;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= RUN;
    else         state_q <= state_d;
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == RUN && load_use) stall_cnt_d = stall_cnt_q + 32'd1;
    if (state_q == FLUSH)           flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Purpose : Directed self-checking bench for pipe_hazard_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic [4:0]  drs, drt, ern, mrn;
  logic        duse_rs, duse_rt, dbranch_taken;
  logic        ewreg, em2reg, ebubble, mwreg, mm2reg;
  logic [1:0]  fwda, fwdb;
  logic        wpcir, dbubble;
  logic [31:0] stall_cnt, flush_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl dut (
    .clock         (clock),
    .resetn        (resetn),
    .drs           (drs),
    .drt           (drt),
    .duse_rs       (duse_rs),
    .duse_rt       (duse_rt),
    .dbranch_taken (dbranch_taken),
    .ern           (ern),
    .ewreg         (ewreg),
    .em2reg        (em2reg),
    .ebubble       (ebubble),
    .mrn           (mrn),
    .mwreg         (mwreg),
    .mm2reg        (mm2reg),
    .fwda          (fwda),
    .fwdb          (fwdb),
    .wpcir         (wpcir),
    .dbubble       (dbubble),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    drs = 5'd0; drt = 5'd0; ern = 5'd0; mrn = 5'd0;
    duse_rs = 1'b0; duse_rt = 1'b0; dbranch_taken = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; ebubble = 1'b0;
    mwreg = 1'b0; mm2reg = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_load_use();
    clr();
    ern = 5'd5; ewreg = 1'b1; em2reg = 1'b1; drs = 5'd5; duse_rs = 1'b1;
  endtask

  initial begin
    clr();
    resetn = 1'b0;
    #2;
    chk("rst_fwda", 32'(fwda), 32'd0);
    chk("rst_fwdb", 32'(fwdb), 32'd0);
    chk("rst_wpcir", 32'(wpcir), 32'd1);
    chk("rst_dbubble", 32'(dbubble), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Load-use then STALL with load in MEM
    set_load_use(); #1;
    chk("lu_wpcir", 32'(wpcir), 32'd0);
    chk("lu_dbubble", 32'(dbubble), 32'd1);
    chk("lu_fwda", 32'(fwda), 32'd0);
    tick();
    clr(); mrn = 5'd5; mwreg = 1'b1; mm2reg = 1'b1; drs = 5'd5; duse_rs = 1'b1; #1;
    chk("stall_fwda", 32'(fwda), 32'd3);
    chk("stall_wpcir", 32'(wpcir), 32'd1);
    chk("stall_dbubble", 32'(dbubble), 32'd0);
    tick();
    clr(); #1;
    chk("post_stall_dbubble", 32'(dbubble), 32'd0);

    // Load in EX but squashed: no stall
    set_load_use(); ebubble = 1'b1; #1;
    chk("lu_bubble_wpcir", 32'(wpcir), 32'd1);

    // Forwarding priority on rt
    clr(); ern = 5'd7; mrn = 5'd7; ewreg = 1'b1; mwreg = 1'b1; drt = 5'd7; duse_rt = 1'b1; #1;
    chk("prio_ex", 32'(fwdb), 32'd1);
    chk("prio_ex_fwda", 32'(fwda), 32'd0);
    ebubble = 1'b1; #1;
    chk("prio_mem_alu", 32'(fwdb), 32'd2);
    mm2reg = 1'b1; #1;
    chk("prio_mem_load", 32'(fwdb), 32'd3);
    duse_rt = 1'b0; #1;
    chk("no_use_rt", 32'(fwdb), 32'd0);
    clr(); ern = 5'd9; ewreg = 1'b1; drs = 5'd9; duse_rs = 1'b1; mrn = 5'd9; mwreg = 1'b1; #1;
    chk("ex_fwda", 32'(fwda), 32'd1);

    // Branch flush
    clr(); dbranch_taken = 1'b1; #1;
    chk("br_wpcir", 32'(wpcir), 32'd1);
    chk("br_dbubble", 32'(dbubble), 32'd0);
    tick();
    set_load_use(); dbranch_taken = 1'b1; #1;
    chk("flush_dbubble", 32'(dbubble), 32'd1);
    chk("flush_wpcir", 32'(wpcir), 32'd1);
    tick();
    clr(); #1;
    chk("post_flush_dbubble", 32'(dbubble), 32'd0);
    chk("post_flush_wpcir", 32'(wpcir), 32'd1);

    // Load-use and branch together
    set_load_use(); dbranch_taken = 1'b1; #1;
    chk("sim_wpcir", 32'(wpcir), 32'd0);
    chk("sim_dbubble", 32'(dbubble), 32'd1);
    tick();
    clr(); dbranch_taken = 1'b1; #1;
    chk("sim_stall_wpcir", 32'(wpcir), 32'd1);
    chk("sim_stall_dbubble", 32'(dbubble), 32'd0);
    tick();
    clr(); #1;
    chk("sim_flush_dbubble", 32'(dbubble), 32'd1);
    tick();
    chk("sim_run_dbubble", 32'(dbubble), 32'd0);

    // Register 0 never forwards or stalls
    clr(); ern = 5'd0; ewreg = 1'b1; em2reg = 1'b1; drs = 5'd0; duse_rs = 1'b1; #1;
    chk("r0_wpcir", 32'(wpcir), 32'd1);
    chk("r0_fwda", 32'(fwda), 32'd0);
    mwreg = 1'b1; mrn = 5'd0; #1;
    chk("r0_mem_fwda", 32'(fwda), 32'd0);

    // Reset mid-FLUSH drops the pending squash
    clr(); dbranch_taken = 1'b1; tick();
    clr(); #1;
    chk("pre_rst_flush", 32'(dbubble), 32'd1);
    resetn = 1'b0; #1;
    chk("rst_in_flush", 32'(dbubble), 32'd0);
    tick(); resetn = 1'b1; #1;
    chk("rst_flush_resume", 32'(dbubble), 32'd0);

    // Reset mid-STALL resumes in RUN (load-use stalls again)
    tick();
    set_load_use(); tick();
    resetn = 1'b0; #1;
    tick(); resetn = 1'b1; #1;
    chk("rst_stall_resume", 32'(wpcir), 32'd0);
    clr(); tick();

    // Counters
    resetn = 1'b0; #1; resetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_load_use(); tick();
      clr(); tick();
    end
    for (int i = 0; i < 2; i++) begin
      clr(); dbranch_taken = 1'b1; tick();
      clr(); tick();
    end
`ifdef PIPE_HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("flush_cnt", flush_cnt, 32'd2);
`else
    chk("stall_cnt_tied", stall_cnt, 32'd0);
    chk("flush_cnt_tied", flush_cnt, 32'd0);
`endif
    #2 resetn = 1'b0; #1;
    chk("cnt_rst_stall", stall_cnt, 32'd0);
    chk("cnt_rst_flush", flush_cnt, 32'd0);
    resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have the following ports: clock, resetn, asynchronous, active-low; clock clock.
REQ-002 clock  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 drs, drt  in  5 each  ID-stage source register numbers.
REQ-005 duse_rs, duse_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 dbranch_taken  in  1  branch/jump resolved taken in ID this cycle.
REQ-007 ern, ewreg, em2reg, ebubble  in  5/1/1/1  EX-stage destination, write enable, load flag, squashed flag.
REQ-008 mrn, mwreg, mm2reg  in  5/1/1  MEM-stage destination, write enable, load flag.
REQ-009 fwda, fwdb  out  2 each  operand select: 00 register file, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-010 wpcir  out  1  PC and IF/ID write enable (0 = hold).
REQ-011 dbubble  out  1  squash the ID instruction (ID/EX receives a bubble).
REQ-012 stall_cnt, flush_cnt  out  32 each  performance counters (present only per REQ-031).

Function
REQ-013 The block SHALL implement states RUN, STALL and FLUSH in a registered 2-bit state; fwda, fwdb, wpcir and dbubble SHALL be combinational from the state and the inputs.
REQ-014 An EX match SHALL require ewreg=1, ebubble=0, ern!=0 and ern equal to the operand register with its use flag set.
REQ-015 A MEM match SHALL require mwreg=1, mrn!=0 and mrn equal to the operand register with its use flag set.
REQ-016 Forwarding SHALL be computed per operand: an EX match with em2reg=0 gives 01; otherwise a MEM match gives 10 if mm2reg=0 or 11 if mm2reg=1; otherwise 00. EX takes priority over MEM.
REQ-017 Load-use SHALL be detected as an EX match with em2reg=1 on either operand.
REQ-018 In RUN with load-use: wpcir=0 and dbubble=1, and the next state SHALL be STALL; dbranch_taken SHALL be ignored in that cycle.
REQ-019 In RUN with dbranch_taken=1 and no load-use: wpcir=1 and dbubble=0, and the next state SHALL be FLUSH.
REQ-020 In RUN otherwise: wpcir=1, dbubble=0, and the state SHALL stay RUN.
REQ-021 In STALL: wpcir=1, dbubble=0, and forwarding SHALL be computed as in REQ-016 (the load is now in MEM, giving 11). Next state: FLUSH if dbranch_taken=1, else RUN.
REQ-022 In FLUSH: dbubble=1, wpcir=1, and dbranch_taken and load-use SHALL be ignored (the wrong-path instruction is squashed). Next state: RUN.
REQ-023 Register 0 SHALL never produce a forward or a stall.
REQ-024 Unused state encoding 11 SHALL return to RUN on the next edge, and outputs in that state SHALL be as in RUN.

Reset
REQ-025 While resetn=0: state=RUN, and stall_cnt and flush_cnt = 0 immediately (asynchronous).
REQ-026 With resetn=0 and all inputs 0: fwda=fwdb=00, wpcir=1, dbubble=0.
REQ-027 Reset deasserted mid-STALL or mid-FLUSH SHALL resume in RUN; no pending squash SHALL be kept.

Configuration
REQ-028 Macro: PIPE_HAZARD_PERF_EN.
REQ-029 When PIPE_HAZARD_PERF_EN is defined, stall_cnt SHALL increment on each edge where the state is RUN and load-use is detected.
REQ-030 When PIPE_HAZARD_PERF_EN is defined, flush_cnt SHALL increment on each edge where the state is FLUSH. Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 When PIPE_HAZARD_PERF_EN is undefined, stall_cnt and flush_cnt SHALL be tied to 0 with no counter flops, and all other behaviour SHALL be identical.

Verification
REQ-032 Load-use: ern=5, ewreg=1, em2reg=1, drs=5, duse_rs=1 -> wpcir=0, dbubble=1; next cycle STALL with mrn=5, mm2reg=1 gives fwda=11 and wpcir=1.
REQ-033 Priority: ern=mrn=7, both wreg=1, em2reg=0, drt=7, duse_rt=1 -> fwdb=01; with ebubble=1 -> fwdb=10.
REQ-034 Branch: dbranch_taken=1 in RUN -> next cycle dbubble=1 and wpcir=1, then RUN with dbubble=0.
REQ-035 Simultaneous events: load-use and dbranch_taken in the same RUN cycle -> STALL, then FLUSH when dbranch_taken=1 is held, then RUN.
REQ-036 Register 0: ern=0, ewreg=1, em2reg=1, drs=0, duse_rs=1 -> no stall and fwda=00.
REQ-037 Counters (PIPE_HAZARD_PERF_EN defined): 3 load-use stalls and 2 flushes -> stall_cnt=3, flush_cnt=2; pulsing resetn low -> both 0 immediately.
